audio_codec_controller: RTL and testbench
=========================================

# audio_codec_controller

Bridges the CLOCK_50 system domain and the board's WM8731 audio codec over its I2S serial interface. Deserialises ADC stereo samples into receive FIFOs and serialises DAC stereo samples from transmit FIFOs. Generates the codec master clock AUD_XCK. Sits between the game's tone generator, which consumes input samples and writes mixed output samples, and the codec pins; the codec registers are configured separately over I2C.

## Interface
Parameters:
- DATA_WIDTH, 32: bits per channel sample, MSB first on the wire.
- FIFO_DEPTH, 128: words per channel FIFO; power of two, at least 4.

Ports:
- CLOCK_50  in  1: system clock, 50 MHz.
- reset  in  1: synchronous, active-high; clock CLOCK_50.
- clear_audio_in_memory  in  1: flush both receive FIFOs.
- read_audio_in  in  1: pop one stereo pair from the receive FIFOs.
- clear_audio_out_memory  in  1: flush both transmit FIFOs.
- left_channel_audio_out  in  DATA_WIDTH: left sample to transmit.
- right_channel_audio_out  in  DATA_WIDTH: right sample to transmit.
- write_audio_out  in  1: push one stereo pair into the transmit FIFOs.
- AUD_ADCDAT  in  1: serial ADC data from the codec.
- AUD_BCLK  inout  1: bit clock, codec-driven; the block drives Z and only reads it.
- AUD_ADCLRCK  inout  1: ADC L/R frame clock, codec-driven; the block drives Z.
- AUD_DACLRCK  inout  1: DAC L/R frame clock, codec-driven; the block drives Z.
- audio_in_available  out  1: both receive FIFOs are non-empty.
- left_channel_audio_in  out  DATA_WIDTH: head of the left receive FIFO.
- right_channel_audio_in  out  DATA_WIDTH: head of the right receive FIFO.
- audio_out_allowed  out  1: both transmit FIFOs are non-full.
- AUD_XCK  out  1: codec master clock, CLOCK_50/4 = 12.5 MHz.
- AUD_DACDAT  out  1: serial DAC data to the codec.

## Operation
- Codec runs in master mode, so BCLK and both LRCKs are inputs. Each passes through a 2-FF synchroniser, followed by a registered previous-value copy for rise/fall detection.
- Frame format is I2S:
  - LRCK low means left channel; LRCK high means right channel.
  - The MSB falls on the second BCLK rising edge after an LRCK edge, i.e. one bit delay.
- ADC path:
  - After each ADCLRCK edge, skip one BCLK rise, then shift AUD_ADCDAT in on the next DATA_WIDTH BCLK rises. Ignore any further bits until the next ADCLRCK edge.
  - A completed left word is held in a left staging register.
  - When a right word completes, push {staged left, right} into both receive FIFOs together.
  - If either receive FIFO is full, drop the pair (overrun). FIFO contents are unchanged.
- Receive read:
  - The receive FIFOs are first-word-fall-through, so the left/right_channel_audio_in outputs show the heads directly.
  - read_audio_in while audio_in_available pops both FIFOs. read_audio_in while not available is ignored.
- DAC path:
  - On a DACLRCK falling edge, load the left word from the transmit FIFO head into the shift register.
  - On a DACLRCK rising edge, load the right word, then pop both transmit FIFOs.
  - If the transmit FIFOs are empty at a load, load zero and do not pop (underrun).
  - Shift out MSB first: AUD_DACDAT updates on BCLK falling edges. The first falling edge after an LRCK edge outputs 0; the next DATA_WIDTH falling edges output the data bits; then 0 until the next LRCK edge.
- Transmit write: write_audio_out while audio_out_allowed pushes both samples. write_audio_out while not allowed is ignored.
- Clear inputs empty the corresponding FIFO pair in one cycle. A clear has priority over a same-cycle push or pop.
- Simultaneous push and pop on a FIFO that is neither empty nor full keep the count unchanged.
- AUD_XCK is a 2-bit free-running counter's MSB. The counter is reset to 0.

## Timing
- Reset values:
  - All FIFOs empty, so audio_in_available=0 and audio_out_allowed=1.
  - left/right_channel_audio_in = 0.
  - AUD_DACDAT=0, AUD_XCK=0.
  - Shift registers, bit counters and synchronisers cleared.
- Reset mid-frame abandons the partial word in both paths. Operation resumes at the next LRCK edge.
- Pin-to-detect latency is 3 CLOCK_50 cycles (2 synchroniser stages + edge register).
- A push becomes visible on audio_in_available / the data outputs the cycle after the push.
- audio_in_available and audio_out_allowed are combinational from the FIFO counts. A pop or push updates them the following cycle.
- The required BCLK is at most 6.25 MHz, i.e. at least 8 CLOCK_50 cycles per BCLK period.

## Structure
- Shared package audio_codec_pkg holds:
  - DATA_WIDTH and FIFO_DEPTH defaults.
  - A typedef for the stereo pair.
  - The I2S channel-polarity constant (left = LRCK low).
- One sub-module, audio_sync_fifo: single-clock FWFT FIFO with ports push, pop, clear, data_in, data_out, empty, full. It is instantiated four times.
- The serialiser and deserialiser stay inline as always blocks.

## Test plan
- Reset then idle -> audio_in_available=0, audio_out_allowed=1, AUD_DACDAT=0, AUD_XCK toggles every 2 cycles.
- Bench codec model sends left 32'hA5A5_0001 and right 32'h5A5A_0002 in I2S at BCLK=CLOCK_50/16 -> audio_in_available=1, outputs equal those values; read_audio_in for 1 cycle -> available=0.
- write_audio_out with left 32'h8000_0001, right 32'h0000_FFFF, then one frame -> the model captures exactly those bits MSB-first with a one-bit delay; the following frame transmits zeros.
- Fill the transmit FIFOs with FIFO_DEPTH pairs -> audio_out_allowed=0; an extra write is ignored; one frame pops -> audio_out_allowed=1.
- Feed FIFO_DEPTH+1 ADC frames with no reads -> exactly FIFO_DEPTH pairs are stored and read back in order; the last frame is dropped.
- Assert reset mid-word, then clear_audio_in_memory together with read_audio_in -> FIFOs empty, no spurious pair; the next complete frame is received correctly.

Source files
------------

// File: rtl/audio_codec_pkg.sv
// Shared defaults, sample-pair type and I2S channel polarity for the audio codec controller.
package audio_codec_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH = 128;

    // I2S: LRCK low carries the left channel.
    localparam logic LRCK_LEFT = 1'b0;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] left;
        logic [DEFAULT_DATA_WIDTH-1:0] right;
    } stereo_pair_t;
endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads as zero while empty.
module audio_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push && !clear && !reset) mem[wr_ptr] <= data_in;
    end
endmodule

// File: rtl/audio_codec_controller.sv
// WM8731 I2S bridge: codec-mastered BCLK/LRCK, ADC deserialiser into RX FIFOs,
// DAC serialiser from TX FIFOs, and the AUD_XCK master clock divider.
module audio_codec_controller
    import audio_codec_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  clear_audio_in_memory,
    input  logic                  read_audio_in,
    input  logic                  clear_audio_out_memory,
    input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                  write_audio_out,
    input  logic                  AUD_ADCDAT,
    inout  wire                   AUD_BCLK,
    inout  wire                   AUD_ADCLRCK,
    inout  wire                   AUD_DACLRCK,
    output logic                  audio_in_available,
    output logic [DATA_WIDTH-1:0] left_channel_audio_in,
    output logic [DATA_WIDTH-1:0] right_channel_audio_in,
    output logic                  audio_out_allowed,
    output logic                  AUD_XCK,
    output logic                  AUD_DACDAT
);
    localparam int CW = $clog2(DATA_WIDTH + 2);

    assign AUD_BCLK    = 1'bz;
    assign AUD_ADCLRCK = 1'bz;
    assign AUD_DACLRCK = 1'bz;

    logic [1:0] xck_cnt;
    always_ff @(posedge CLOCK_50) begin
        if (reset) xck_cnt <= '0;
        else       xck_cnt <= xck_cnt + 1'b1;
    end
    assign AUD_XCK = xck_cnt[1];

    logic [1:0] bclk_sync, adclrck_sync, daclrck_sync, adcdat_sync;
    logic       bclk_prev, adclrck_prev, daclrck_prev;
    logic [2:0] settle;

    // Edges are masked until the synchroniser and previous-value stages refill after reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bclk_sync    <= '0;
            adclrck_sync <= '0;
            daclrck_sync <= '0;
            adcdat_sync  <= '0;
            bclk_prev    <= 1'b0;
            adclrck_prev <= 1'b0;
            daclrck_prev <= 1'b0;
            settle       <= '0;
        end else begin
            bclk_sync    <= {bclk_sync[0], AUD_BCLK};
            adclrck_sync <= {adclrck_sync[0], AUD_ADCLRCK};
            daclrck_sync <= {daclrck_sync[0], AUD_DACLRCK};
            adcdat_sync  <= {adcdat_sync[0], AUD_ADCDAT};
            bclk_prev    <= bclk_sync[1];
            adclrck_prev <= adclrck_sync[1];
            daclrck_prev <= daclrck_sync[1];
            settle       <= {settle[1:0], 1'b1};
        end
    end

    logic bclk_rise, bclk_fall, adc_edge, dac_edge, dac_rise;
    assign bclk_rise = settle[2] &&  bclk_sync[1] && !bclk_prev;
    assign bclk_fall = settle[2] && !bclk_sync[1] &&  bclk_prev;
    assign adc_edge  = settle[2] && (adclrck_sync[1] != adclrck_prev);
    assign dac_edge  = settle[2] && (daclrck_sync[1] != daclrck_prev);
    assign dac_rise  = dac_edge && daclrck_sync[1];

    logic                  rx_push, rx_pop, tx_push, tx_pop;
    logic                  rx_empty_l, rx_empty_r, rx_full_l, rx_full_r;
    logic                  tx_empty_l, tx_empty_r, tx_full_l, tx_full_r;
    logic [DATA_WIDTH-1:0] tx_head_l, tx_head_r;

    assign audio_in_available = !rx_empty_l && !rx_empty_r;
    assign audio_out_allowed  = !tx_full_l && !tx_full_r;
    assign rx_pop  = read_audio_in && audio_in_available;
    assign tx_push = write_audio_out && audio_out_allowed;

    // ADC: cnt 0 waits out the one-bit delay, 1..DATA_WIDTH shift, beyond that idle.
    logic                  adc_armed, adc_chan, left_valid, word_done;
    logic [CW-1:0]         adc_cnt;
    logic [DATA_WIDTH-1:0] adc_shift, adc_word, left_stage;

    assign adc_word  = {adc_shift[DATA_WIDTH-2:0], adcdat_sync[1]};
    assign word_done = adc_armed && bclk_rise && !adc_edge && (adc_cnt == CW'(DATA_WIDTH));
    assign rx_push   = word_done && (adc_chan != LRCK_LEFT) && left_valid && !rx_full_l && !rx_full_r;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            adc_armed  <= 1'b0;
            adc_chan   <= 1'b0;
            adc_cnt    <= '0;
            adc_shift  <= '0;
            left_stage <= '0;
            left_valid <= 1'b0;
        end else if (adc_edge) begin
            adc_armed <= 1'b1;
            adc_chan  <= adclrck_sync[1];
            adc_cnt   <= '0;
            if (adclrck_sync[1] == LRCK_LEFT) left_valid <= 1'b0;
        end else if (adc_armed && bclk_rise && adc_cnt <= CW'(DATA_WIDTH)) begin
            if (adc_cnt != '0) adc_shift <= adc_word;
            adc_cnt <= adc_cnt + 1'b1;
            if (word_done) begin
                if (adc_chan == LRCK_LEFT) begin
                    left_stage <= adc_word;
                    left_valid <= 1'b1;
                end else begin
                    left_valid <= 1'b0;
                end
            end
        end
    end

    // DAC: the LRCK edge coincides with a BCLK fall in I2S, which then carries the delay bit.
    logic                  dac_armed, dac_lead;
    logic [CW-1:0]         dac_cnt;
    logic [DATA_WIDTH-1:0] dac_shift;

    assign tx_pop = dac_rise && !tx_empty_l && !tx_empty_r;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dac_armed  <= 1'b0;
            dac_lead   <= 1'b0;
            dac_cnt    <= '0;
            dac_shift  <= '0;
            AUD_DACDAT <= 1'b0;
        end else if (dac_edge) begin
            dac_armed  <= 1'b1;
            dac_lead   <= !bclk_fall;
            dac_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
            if (tx_empty_l || tx_empty_r)
                dac_shift <= '0;
            else
                dac_shift <= (daclrck_sync[1] == LRCK_LEFT) ? tx_head_l : tx_head_r;
        end else if (dac_armed && bclk_fall) begin
            if (dac_lead) begin
                dac_lead   <= 1'b0;
                AUD_DACDAT <= 1'b0;
            end else if (dac_cnt < CW'(DATA_WIDTH)) begin
                AUD_DACDAT <= dac_shift[DATA_WIDTH-1];
                dac_shift  <= {dac_shift[DATA_WIDTH-2:0], 1'b0};
                dac_cnt    <= dac_cnt + 1'b1;
            end else begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end

    audio_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_left (
        .CLOCK_50(CLOCK_50), .reset(reset), .push(rx_push), .pop(rx_pop),
        .clear(clear_audio_in_memory), .data_in(left_stage),
        .data_out(left_channel_audio_in), .empty(rx_empty_l), .full(rx_full_l));

    audio_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_right (
        .CLOCK_50(CLOCK_50), .reset(reset), .push(rx_push), .pop(rx_pop),
        .clear(clear_audio_in_memory), .data_in(adc_word),
        .data_out(right_channel_audio_in), .empty(rx_empty_r), .full(rx_full_r));

    audio_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_left (
        .CLOCK_50(CLOCK_50), .reset(reset), .push(tx_push), .pop(tx_pop),
        .clear(clear_audio_out_memory), .data_in(left_channel_audio_out),
        .data_out(tx_head_l), .empty(tx_empty_l), .full(tx_full_l));

    audio_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_right (
        .CLOCK_50(CLOCK_50), .reset(reset), .push(tx_push), .pop(tx_pop),
        .clear(clear_audio_out_memory), .data_in(right_channel_audio_out),
        .data_out(tx_head_r), .empty(tx_empty_r), .full(tx_full_r));
endmodule

// File: tb/tb_audio_codec_controller.sv
// Directed bench: an I2S codec model drives BCLK/LRCK/ADCDAT and captures DACDAT.
module tb_audio_codec_controller;
    import audio_codec_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int BPH   = DW + 2;
    localparam int HALF  = 8;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          clear_in = 1'b0, read_in = 1'b0, clear_out = 1'b0, write_out = 1'b0;
    logic [DW-1:0] lout = '0, rout = '0;
    logic          adcdat = 1'b0, bclk_drv = 1'b1, adclrck_drv = 1'b1, daclrck_drv = 1'b1;
    wire           AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK;
    logic          avail, allowed, AUD_XCK, AUD_DACDAT;
    logic [DW-1:0] lin, rin;

    assign AUD_BCLK    = bclk_drv;
    assign AUD_ADCLRCK = adclrck_drv;
    assign AUD_DACLRCK = daclrck_drv;

    int checks = 0, failures = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_codec_controller #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .clear_audio_in_memory(clear_in), .read_audio_in(read_in),
        .clear_audio_out_memory(clear_out),
        .left_channel_audio_out(lout), .right_channel_audio_out(rout),
        .write_audio_out(write_out), .AUD_ADCDAT(adcdat),
        .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_DACLRCK(AUD_DACLRCK),
        .audio_in_available(avail), .left_channel_audio_in(lin),
        .right_channel_audio_in(rin), .audio_out_allowed(allowed),
        .AUD_XCK(AUD_XCK), .AUD_DACDAT(AUD_DACDAT));

    // One LRCK half: LRCK changes with the first BCLK fall; ADC MSB follows one bit later.
    task automatic send_half(input logic ch, input logic [DW-1:0] adc_w, input int nbits,
                             output logic [DW-1:0] dac_w, output int stray);
        dac_w = '0;
        stray = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge CLOCK_50);
            bclk_drv = 1'b0;
            if (i == 0) begin
                adclrck_drv = ch;
                daclrck_drv = ch;
            end
            adcdat = (i >= 1 && i <= DW) ? adc_w[DW-i] : 1'b0;
            repeat (HALF) @(negedge CLOCK_50);
            bclk_drv = 1'b1;
            if (i >= 1 && i <= DW) dac_w[DW-i] = AUD_DACDAT;
            else if (AUD_DACDAT !== 1'b0) stray++;
            repeat (HALF - 1) @(negedge CLOCK_50);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              output logic [DW-1:0] dl, output logic [DW-1:0] dr, output int stray);
        int s1, s2;
        send_half(1'b0, l, BPH, dl, s1);
        send_half(1'b1, r, BPH, dr, s2);
        stray = s1 + s2;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic write_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(negedge CLOCK_50);
        lout = l;
        rout = r;
        write_out = 1'b1;
        @(negedge CLOCK_50);
        write_out = 1'b0;
    endtask

    task automatic pulse_clear_in();
        @(negedge CLOCK_50);
        clear_in = 1'b1;
        @(negedge CLOCK_50);
        clear_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checks++; if (avail !== 1'b0) begin failures++; $display("FAIL reset_avail got=%b exp=0", avail); end
        checks++; if (allowed !== 1'b1) begin failures++; $display("FAIL reset_allowed got=%b exp=1", allowed); end
        checks++; if (AUD_DACDAT !== 1'b0) begin failures++; $display("FAIL reset_dacdat got=%b exp=0", AUD_DACDAT); end
        checks++; if (AUD_XCK !== 1'b0) begin failures++; $display("FAIL reset_xck got=%b exp=0", AUD_XCK); end
        checks++; if (lin !== '0 || rin !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", lin, rin); end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            logic exp_x;
            @(negedge CLOCK_50);
            exp_x = ((k % 4) >= 2);
            checks++; if (AUD_XCK !== exp_x) begin failures++; $display("FAIL xck_cycle%0d got=%b exp=%b", k, AUD_XCK, exp_x); end
        end
    endtask

    task automatic test_adc_receive();
        logic [DW-1:0] dl, dr;
        int stray;
        send_frame(32'hA5A5_0001, 32'h5A5A_0002, dl, dr, stray);
        checks++; if (avail !== 1'b1) begin failures++; $display("FAIL adc_avail got=%b exp=1", avail); end
        checks++; if (lin !== 32'hA5A5_0001) begin failures++; $display("FAIL adc_left got=%h exp=a5a50001", lin); end
        checks++; if (rin !== 32'h5A5A_0002) begin failures++; $display("FAIL adc_right got=%h exp=5a5a0002", rin); end
        checks++; if (dl !== '0 || dr !== '0 || stray != 0) begin failures++; $display("FAIL underrun_zero got=%h/%h stray=%0d exp=0/0 stray=0", dl, dr, stray); end
        @(negedge CLOCK_50);
        read_in = 1'b1;
        @(negedge CLOCK_50);
        read_in = 1'b0;
        checks++; if (avail !== 1'b0) begin failures++; $display("FAIL adc_after_read got=%b exp=0", avail); end
    endtask

    task automatic test_dac_transmit();
        logic [DW-1:0] dl, dr;
        int stray;
        write_pair(32'h8000_0001, 32'h0000_FFFF);
        send_frame('0, '0, dl, dr, stray);
        checks++; if (dl !== 32'h8000_0001) begin failures++; $display("FAIL dac_left got=%h exp=80000001", dl); end
        checks++; if (dr !== 32'h0000_FFFF) begin failures++; $display("FAIL dac_right got=%h exp=0000ffff", dr); end
        checks++; if (stray != 0) begin failures++; $display("FAIL dac_delay_bits got=%0d exp=0", stray); end
        send_frame('0, '0, dl, dr, stray);
        checks++; if (dl !== '0 || dr !== '0 || stray != 0) begin failures++; $display("FAIL dac_next_zero got=%h/%h stray=%0d exp=0/0 stray=0", dl, dr, stray); end
        pulse_clear_in();
    endtask

    task automatic test_tx_full();
        stereo_pair_t  tab [DEPTH];
        logic [DW-1:0] dl, dr;
        int stray;
        for (int i = 0; i < DEPTH; i++) begin
            tab[i].left  = 32'h1111_0000 + 32'(i);
            tab[i].right = 32'h2222_0000 + 32'(i);
            write_pair(tab[i].left, tab[i].right);
        end
        checks++; if (allowed !== 1'b0) begin failures++; $display("FAIL tx_full_allowed got=%b exp=0", allowed); end
        write_pair(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        for (int i = 0; i < DEPTH; i++) begin
            send_frame('0, '0, dl, dr, stray);
            checks++; if (dl !== tab[i].left || dr !== tab[i].right) begin
                failures++; $display("FAIL tx_full_frame%0d got=%h/%h exp=%h/%h", i, dl, dr, tab[i].left, tab[i].right);
            end
            if (i == 0) begin
                checks++; if (allowed !== 1'b1) begin failures++; $display("FAIL tx_after_pop_allowed got=%b exp=1", allowed); end
            end
        end
        send_frame('0, '0, dl, dr, stray);
        checks++; if (dl !== '0 || dr !== '0) begin failures++; $display("FAIL tx_extra_ignored got=%h/%h exp=0/0", dl, dr); end
        pulse_clear_in();
    endtask

    task automatic test_overrun();
        logic [DW-1:0] dl, dr;
        int stray;
        checks++; if (avail !== 1'b0) begin failures++; $display("FAIL overrun_start got=%b exp=0", avail); end
        for (int f = 0; f <= DEPTH; f++)
            send_frame(32'h1000_0000 + 32'(f), 32'h2000_0000 + 32'(f), dl, dr, stray);
        for (int k = 0; k < DEPTH; k++) begin
            checks++; if (avail !== 1'b1 || lin !== 32'h1000_0000 + 32'(k) || rin !== 32'h2000_0000 + 32'(k)) begin
                failures++; $display("FAIL overrun_pair%0d got=%b %h/%h exp=1 %h/%h", k, avail, lin, rin,
                                     32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k));
            end
            @(negedge CLOCK_50);
            read_in = 1'b1;
            @(negedge CLOCK_50);
            read_in = 1'b0;
        end
        checks++; if (avail !== 1'b0) begin failures++; $display("FAIL overrun_dropped got=%b exp=0", avail); end
    endtask

    task automatic test_reset_mid_word();
        logic [DW-1:0] dl, dr;
        int stray;
        send_half(1'b0, 32'hFFFF_0000, 10, dl, stray);
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        checks++; if (AUD_DACDAT !== 1'b0) begin failures++; $display("FAIL midreset_dacdat got=%b exp=0", AUD_DACDAT); end
        send_half(1'b1, 32'h1234_5678, BPH, dr, stray);
        repeat (4) @(negedge CLOCK_50);
        checks++; if (avail !== 1'b0) begin failures++; $display("FAIL midreset_no_pair got=%b exp=0", avail); end
        send_frame(32'hC0DE_0001, 32'hC0DE_0002, dl, dr, stray);
        checks++; if (avail !== 1'b1) begin failures++; $display("FAIL midreset_frame_avail got=%b exp=1", avail); end
        @(negedge CLOCK_50);
        clear_in = 1'b1;
        read_in  = 1'b1;
        @(negedge CLOCK_50);
        clear_in = 1'b0;
        read_in  = 1'b0;
        checks++; if (avail !== 1'b0 || lin !== '0) begin failures++; $display("FAIL clear_with_read got=%b %h exp=0 0", avail, lin); end
        send_frame(32'h3C3C_1111, 32'h4B4B_2222, dl, dr, stray);
        checks++; if (avail !== 1'b1 || lin !== 32'h3C3C_1111 || rin !== 32'h4B4B_2222) begin
            failures++; $display("FAIL recover_frame got=%b %h/%h exp=1 3c3c1111/4b4b2222", avail, lin, rin);
        end
    endtask

    initial begin
        test_reset();
        test_adc_receive();
        test_dac_transmit();
        test_tx_full();
        test_overrun();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
